// File: rtl/alu4_acc_ctrl.sv
// alu4_acc_ctrl: accumulator command controller driving an external combinational 4-bit ALU
module alu4_acc_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_acc,
  output logic [3:0]       rsp_flags,
  output logic             sticky_v,
  output logic [CNT_W-1:0] op_count,
  output logic             busy,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [3:0] op_q, data_q, acc, flags;
  logic accept;
  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  assign rsp_acc   = acc;
  assign rsp_flags = flags;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? EXEC : IDLE) :
              state == EXEC ? RESP :
              (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      data_q   <= '0;
      acc      <= '0;
      flags    <= '0;
      sticky_v <= 1'b0;
      op_count <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        alu_a  <= acc;
        alu_b  <= cmd_data;
        alu_op <= cmd_op[2:0];
      end
      if (state == EXEC) begin
        if (!op_q[3]) begin
          acc      <= alu_result;
          flags    <= {alu_c, alu_n, alu_z, alu_v};
          sticky_v <= sticky_v | alu_v;
          op_count <= op_count + {{(CNT_W-1){1'b0}}, ~&op_count};
        end else if (op_q == 4'b1000) begin
          acc   <= data_q;
          flags <= {1'b0, data_q[3], data_q == 4'd0, 1'b0};
        end else if (op_q == 4'b1001) begin
          flags    <= '0;
          sticky_v <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu4_acc_ctrl.sv
// tb_alu4_acc_ctrl: table-driven scoreboard bench with a behavioural alu4 and CNT_W=2
module tb_alu4_acc_ctrl;
  localparam int CNT_W = 2;
  logic clk = 1'b0, rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, sticky_v, busy;
  logic [3:0] cmd_op, cmd_data, rsp_acc, rsp_flags, alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic [CNT_W-1:0] op_count;
  logic alu_c, alu_n, alu_z, alu_v;
  typedef struct {
    logic [3:0] op;
    logic [3:0] data;
    logic [3:0] acc;
    logic [3:0] flags;
    logic       sticky;
    logic [1:0] cnt;
  } vec_t;
  vec_t tbl[15];
  vec_t q[$];
  int n_pass = 0, n_total = 0;
  logic [3:0] cur_acc = 4'd0;
  always #5 clk = ~clk;
  alu4_acc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_acc(rsp_acc),
    .rsp_flags(rsp_flags), .sticky_v(sticky_v), .op_count(op_count), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v)
  );
  // alu4 reference: returns {result, c, n, z, v}; SUB carry is the borrow
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic c, v;
    s = 5'd0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: r = ~a;
      3'd1: r = ~b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      default: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
    endcase
    return {r, c, r[3], r == 4'd0, v};
  endfunction
  always_comb {alu_result, alu_c, alu_n, alu_z, alu_v} = alu_f(alu_a, alu_b, alu_op);
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // rsp_ready only changes just after posedge, so its negedge value is the handshake value
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", 16'd1, 16'd0);
      else begin
        vec_t e;
        e = q.pop_front();
        chk("rsp", {rsp_acc, rsp_flags, 3'd0, sticky_v, 2'd0, op_count},
                   {e.acc, e.flags, 3'd0, e.sticky, 2'd0, e.cnt});
      end
    end
  end
  task automatic do_cmd(input vec_t e);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = e.op;
    cmd_data  = e.data;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("cmd_ready_timeout", 16'd0, 16'd1);
    q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_alu", {alu_a, alu_b, 1'b0, alu_op, busy, cmd_ready, rsp_valid, 1'b0},
                    {cur_acc, e.data, 1'b0, e.op[2:0], 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    chk("resp_latency", {15'd0, rsp_valid}, 16'd1);
    cur_acc = e.acc;
  endtask
  initial begin
    tbl[0]  = '{4'h8, 4'h5, 4'h5, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{4'h6, 4'h3, 4'h8, 4'b0101, 1'b1, 2'd1};
    tbl[2]  = '{4'h8, 4'h5, 4'h5, 4'b0000, 1'b1, 2'd1};
    tbl[3]  = '{4'h7, 4'h2, 4'h3, 4'b0000, 1'b1, 2'd2};
    tbl[4]  = '{4'h9, 4'h6, 4'h3, 4'b0000, 1'b0, 2'd2};
    tbl[5]  = '{4'h8, 4'hF, 4'hF, 4'b0100, 1'b0, 2'd2};
    tbl[6]  = '{4'h4, 4'hF, 4'h0, 4'b0010, 1'b0, 2'd3};
    tbl[7]  = '{4'h1, 4'h0, 4'hF, 4'b0100, 1'b0, 2'd3};
    tbl[8]  = '{4'hA, 4'h7, 4'hF, 4'b0100, 1'b0, 2'd3};
    tbl[9]  = '{4'h2, 4'h0, 4'h0, 4'b0010, 1'b0, 2'd3};
    tbl[10] = '{4'h7, 4'h1, 4'hF, 4'b1100, 1'b0, 2'd3};
    tbl[11] = '{4'h6, 4'h1, 4'h0, 4'b1010, 1'b0, 2'd3};
    tbl[12] = '{4'h3, 4'hA, 4'hA, 4'b0100, 1'b0, 2'd3};
    tbl[13] = '{4'h5, 4'h5, 4'h0, 4'b0010, 1'b0, 2'd3};
    tbl[14] = '{4'h0, 4'h9, 4'hF, 4'b0100, 1'b0, 2'd3};
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 4'd0;
    cmd_data = 4'd0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", {15'd0, cmd_ready}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {rsp_acc, rsp_flags, sticky_v, rsp_valid, busy, cmd_ready, 2'd0, op_count},
                       {4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0});
    chk("reset_alu", {1'b0, alu_op, alu_a, alu_b, 4'd0}, 16'd0);
    foreach (tbl[i]) do_cmd(tbl[i]);
    // backpressure with a different command held on the cmd port
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    do_cmd('{4'h8, 4'h3, 4'h3, 4'b0000, 1'b0, 2'd3});
    cmd_valid = 1'b1;
    cmd_op    = 4'h6;
    cmd_data  = 4'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, cmd_ready, 2'd0, rsp_acc, rsp_flags, 4'd0}, {1'b1, 1'b0, 2'd0, 4'h3, 4'h0, 4'd0});
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    q.push_back('{4'h6, 4'h1, 4'h4, 4'b0000, 1'b0, 2'd3});
    @(negedge clk);
    chk("bp_not_ready_at_hs", {15'd0, cmd_ready}, 16'd0);
    @(negedge clk);
    chk("bp_ready_after_hs", {14'd0, cmd_ready, busy}, {14'd0, 1'b1, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_held_exec", {busy, 3'd0, alu_a, alu_b, 1'b0, alu_op}, {1'b1, 3'd0, 4'h3, 4'h1, 1'b0, 3'd6});
    @(negedge clk);
    chk("bp_held_rsp", {15'd0, rsp_valid}, 16'd1);
    cur_acc = 4'h4;
    // reset during EXEC of an overflowing ADD drops the command
    do_cmd('{4'h8, 4'h7, 4'h7, 4'b0000, 1'b0, 2'd3});
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'h6;
    cmd_data  = 4'h7;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_exec_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_exec", {rsp_acc, rsp_flags, sticky_v, rsp_valid, busy, cmd_ready, 2'd0, op_count}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {14'd0, cmd_ready, rsp_valid}, {14'd0, 1'b1, 1'b0});
    cur_acc = 4'h0;
    for (int i = 0; i < 5; i++) do_cmd('{4'h6, 4'h0, 4'h0, 4'b0010, 1'b0, (i < 3) ? 2'(i + 1) : 2'd3});
    chk("sat_count", {14'd0, op_count}, 16'd3);
    @(negedge clk);
    chk("queue_empty", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
